// File: rtl/gfx_pkg.sv
// ============================================================================
//  Module      : gfx_pkg
//  Description : Shared graphics constants, sweep FSM states and address helper
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package gfx_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int XW       = 8;
    localparam int YW       = 7;
    localparam int AW       = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        FINISH = 2'd2
    } sweep_state_e;

    // Linear framebuffer address; multiply by a constant reduces to shift-add.
    function automatic logic [AW-1:0] xy_to_addr(input logic [XW-1:0] x,
                                                 input logic [YW-1:0] y);
        return AW'(x) + AW'(y) * AW'(SCREEN_W);
    endfunction

endpackage

`default_nettype wire

// File: rtl/raster_counter.sv
// ============================================================================
//  Module      : raster_counter
//  Description : Nested x/y raster counter with registered linear address
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module raster_counter #(
    parameter int SCREEN_W = 160,
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int AW       = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [XW-1:0] i_x0,
    input  logic [YW-1:0] i_y0,
    input  logic [XW-1:0] i_x_end,
    input  logic [YW-1:0] i_y_end,
    input  logic          i_advance,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic [AW-1:0] o_addr,
    output logic          o_last
);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [AW-1:0] r_addr;
    logic [XW-1:0] r_x0;
    logic [XW-1:0] r_x_end;
    logic [YW-1:0] r_y_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_addr  <= '0;
            r_x0    <= '0;
            r_x_end <= '0;
            r_y_end <= '0;
        end else if (i_load) begin
            r_x     <= i_x0;
            r_y     <= i_y0;
            r_x0    <= i_x0;
            r_x_end <= i_x_end;
            r_y_end <= i_y_end;
            r_addr  <= AW'(i_x0) + AW'(i_y0) * AW'(SCREEN_W);
        end else if (i_advance) begin
            if (r_x < r_x_end) begin
                r_x    <= r_x + 1'b1;
                r_addr <= r_addr + 1'b1;
            end else begin
                r_x <= r_x0;
                if (r_y < r_y_end) begin
                    // Rewind to the row start, then step down one screen row.
                    r_y    <= r_y + 1'b1;
                    r_addr <= r_addr - AW'(r_x - r_x0) + AW'(SCREEN_W);
                end
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_addr = r_addr;
    assign o_last = (r_x == r_x_end) && (r_y == r_y_end);

endmodule

`default_nettype wire

// File: rtl/rect_sweep_gen.sv
// ============================================================================
//  Module      : rect_sweep_gen
//  Description : Clipped rectangle / full-screen raster sweep with valid/ready
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module rect_sweep_gen #(
    parameter int SCREEN_W = gfx_pkg::SCREEN_W,
    parameter int SCREEN_H = gfx_pkg::SCREEN_H,
    parameter int XW       = gfx_pkg::XW,
    parameter int YW       = gfx_pkg::YW,
    parameter int AW       = gfx_pkg::AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          full_screen,
    input  logic [XW-1:0] rect_x0,
    input  logic [YW-1:0] rect_y0,
    input  logic [XW-1:0] rect_w,
    input  logic [YW-1:0] rect_h,
    input  logic          ready,
    output logic          valid,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y,
    output logic [AW-1:0] out_addr,
    output logic          busy,
    output logic          done
);

    import gfx_pkg::*;

    sweep_state_e  r_state;
    sweep_state_e  w_state_nxt;

    logic [XW:0]   w_xsum;
    logic [XW:0]   w_xlim;
    logic [YW:0]   w_ysum;
    logic [YW:0]   w_ylim;
    logic [XW-1:0] w_x0;
    logic [XW-1:0] w_x_end;
    logic [YW-1:0] w_y0;
    logic [YW-1:0] w_y_end;
    logic          w_empty;
    logic          w_load;
    logic          w_advance;
    logic          w_last;

    // Region bounds: sums carry an extra bit so x0+w never wraps before clipping.
    always_comb begin
        w_xsum  = {1'b0, rect_x0} + {1'b0, rect_w};
        w_ysum  = {1'b0, rect_y0} + {1'b0, rect_h};
        w_xlim  = (w_xsum > (XW+1)'(SCREEN_W)) ? (XW+1)'(SCREEN_W) : w_xsum;
        w_ylim  = (w_ysum > (YW+1)'(SCREEN_H)) ? (YW+1)'(SCREEN_H) : w_ysum;
        w_x0    = rect_x0;
        w_y0    = rect_y0;
        w_x_end = XW'(w_xlim - 1'b1);
        w_y_end = YW'(w_ylim - 1'b1);
        w_empty = (rect_w == '0) || (rect_h == '0) ||
                  ({1'b0, rect_x0} >= (XW+1)'(SCREEN_W)) ||
                  ({1'b0, rect_y0} >= (YW+1)'(SCREEN_H));
        if (full_screen) begin
            w_x0    = '0;
            w_y0    = '0;
            w_x_end = XW'(SCREEN_W - 1);
            w_y_end = YW'(SCREEN_H - 1);
            w_empty = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = !w_empty;
                    w_state_nxt = w_empty ? FINISH : SWEEP;
                end
            end
            SWEEP: begin
                if (ready) begin
                    if (w_last) begin
                        w_state_nxt = FINISH;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            FINISH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    raster_counter #(
        .SCREEN_W (SCREEN_W),
        .XW       (XW),
        .YW       (YW),
        .AW       (AW)
    ) u_raster (
        .clk       (clk),
        .rst       (reset),
        .i_load    (w_load),
        .i_x0      (w_x0),
        .i_y0      (w_y0),
        .i_x_end   (w_x_end),
        .i_y_end   (w_y_end),
        .i_advance (w_advance),
        .o_x       (out_x),
        .o_y       (out_y),
        .o_addr    (out_addr),
        .o_last    (w_last)
    );

    assign valid = (r_state == SWEEP);
    assign busy  = (r_state != IDLE);
    assign done  = (r_state == FINISH);

endmodule

`default_nettype wire

// File: tb/tb_rect_sweep_gen.sv
// ============================================================================
//  Module      : tb_rect_sweep_gen
//  Description : Self-checking bench for rect_sweep_gen against a raster model
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_rect_sweep_gen;

    localparam int W = 160;
    localparam int H = 120;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       full_screen;
    logic [7:0] rect_x0;
    logic [6:0] rect_y0;
    logic [7:0] rect_w;
    logic [6:0] rect_h;
    logic       ready;
    logic       valid;
    logic [7:0] out_x;
    logic [6:0] out_y;
    logic [14:0] out_addr;
    logic       busy;
    logic       done;

    rect_sweep_gen dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .full_screen (full_screen),
        .rect_x0     (rect_x0),
        .rect_y0     (rect_y0),
        .rect_w      (rect_w),
        .rect_h      (rect_h),
        .ready       (ready),
        .valid       (valid),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_addr    (out_addr),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int a;
    } beat_t;

    beat_t expq[$];
    beat_t cap[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    bit    chk_en = 1'b0;
    bit    prev_done = 1'b0;
    int    xfer_cnt;
    int    done_cnt;
    int    done_cyc;
    int    last_xfer_cyc;
    int    first_valid_cyc;
    int    hold_cnt;
    int    start_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference raster: every on-screen pixel of the clipped rectangle, row-major.
    task automatic build_model(input bit full, input int x0, input int y0,
                               input int w, input int h);
        int xs, ys, xe, ye;
        expq.delete();
        xs = full ? 0 : x0;
        ys = full ? 0 : y0;
        xe = full ? W : ((x0 + w > W) ? W : x0 + w);
        ye = full ? H : ((y0 + h > H) ? H : y0 + h);
        for (int y = ys; y < ye; y++)
            for (int x = xs; x < xe; x++)
                expq.push_back('{x: x, y: y, a: x + y * W});
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (prev_done) check("busy_after_done", int'(busy), 0);
            if (valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL extra_beat actual=(%0d,%0d)/%0d required=none",
                             out_x, out_y, out_addr);
                end else if (int'(out_x) != expq[0].x || int'(out_y) != expq[0].y ||
                             int'(out_addr) != expq[0].a) begin
                    bad++;
                    $display("FAIL beat actual=(%0d,%0d)/%0d required=(%0d,%0d)/%0d",
                             out_x, out_y, out_addr, expq[0].x, expq[0].y, expq[0].a);
                end
                if (out_x == 8'd11 && out_y == 7'd20) hold_cnt++;
                if (ready && expq.size() != 0) begin
                    cap.push_back('{x: int'(out_x), y: int'(out_y), a: int'(out_addr)});
                    void'(expq.pop_front());
                    xfer_cnt++;
                    last_xfer_cyc = cyc;
                end
            end else if (busy && !done) begin
                check("bubble_valid", int'(valid), 1);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("beats_left_at_done", expq.size(), 0);
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic run_sweep(input bit full, input int x0, input int y0,
                             input int w, input int h,
                             input int stall_beat, input int stall_len,
                             input int poke);
        int n;
        int slen;
        slen = stall_len;
        build_model(full, x0, y0, w, h);
        cap.delete();
        xfer_cnt        = 0;
        done_cnt        = 0;
        first_valid_cyc = -1;
        last_xfer_cyc   = -1;
        done_cyc        = -1;
        hold_cnt        = 0;
        @(posedge clk); #1;
        full_screen = full;
        rect_x0     = 8'(x0);
        rect_y0     = 7'(y0);
        rect_w      = 8'(w);
        rect_h      = 7'(h);
        ready       = 1'b1;
        start       = 1'b1;
        start_cyc   = cyc;
        chk_en      = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
        full_screen = 1'b0;
        rect_x0     = 8'd3;
        rect_w      = 8'd1;
        n = 0;
        while (done_cnt == 0 && n < 25000) begin
            if (xfer_cnt == stall_beat && slen > 0) begin
                ready = 1'b0;
                slen--;
            end else begin
                ready = 1'b1;
            end
            start = (n == poke);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check("done_seen", done_cnt, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("single_done", done_cnt, 1);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        full_screen = 1'b0;
        rect_x0     = '0;
        rect_y0     = '0;
        rect_w      = '0;
        rect_h      = '0;
        ready       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", int'(valid), 0);
        check("rst_busy",  int'(busy), 0);
        check("rst_done",  int'(done), 0);
        check("rst_addr",  int'(out_addr), 0);
        reset = 1'b0;

        // Full screen, ready always high
        run_sweep(1'b1, 0, 0, 0, 0, -1, 0, 10);
        check("full_count", cap.size(), 19200);
        if (cap.size() == 19200) begin
            check("full_first_addr", cap[0].a, 0);
            check("full_161_x", cap[160].x, 0);
            check("full_161_y", cap[160].y, 1);
            check("full_161_addr", cap[160].a, 160);
            check("full_last_x", cap[19199].x, 159);
            check("full_last_y", cap[19199].y, 119);
            check("full_last_addr", cap[19199].a, 19199);
        end
        check("full_first_latency", first_valid_cyc - start_cyc, 1);
        check("full_done_latency", done_cyc - last_xfer_cyc, 1);

        // Small rectangle
        run_sweep(1'b0, 10, 20, 3, 2, -1, 0, -1);
        check("rect_count", cap.size(), 6);
        if (cap.size() == 6) begin
            check("rect_a0", cap[0].a, 3210);
            check("rect_a1", cap[1].a, 3211);
            check("rect_a2", cap[2].a, 3212);
            check("rect_a3", cap[3].a, 3370);
            check("rect_a4", cap[4].a, 3371);
            check("rect_a5", cap[5].a, 3372);
            check("rect_x3", cap[3].x, 10);
            check("rect_y3", cap[3].y, 21);
        end
        check("rect_done_latency", done_cyc - last_xfer_cyc, 1);

        // Same rectangle, downstream stalls three cycles on beat 2
        run_sweep(1'b0, 10, 20, 3, 2, 1, 3, -1);
        check("stall_count", cap.size(), 6);
        check("stall_hold_cycles", hold_cnt, 4);
        if (cap.size() == 6) check("stall_a1", cap[1].a, 3211);

        // Clipping at the bottom-right corner
        run_sweep(1'b0, 158, 118, 5, 5, -1, 0, -1);
        check("clip_count", cap.size(), 4);
        if (cap.size() == 4) begin
            check("clip_a0", cap[0].a, 19038);
            check("clip_a1", cap[1].a, 19039);
            check("clip_a2", cap[2].a, 19198);
            check("clip_a3", cap[3].a, 19199);
        end

        // Empty regions
        run_sweep(1'b0, 10, 20, 0, 4, -1, 0, -1);
        check("empty_w_valid", first_valid_cyc, -1);
        check("empty_w_done_latency", done_cyc - start_cyc, 1);
        run_sweep(1'b0, 160, 5, 4, 4, -1, 0, -1);
        check("empty_x_valid", first_valid_cyc, -1);
        check("empty_x_done_latency", done_cyc - start_cyc, 1);

        // Asynchronous reset in the middle of a full-screen sweep
        build_model(1'b1, 0, 0, 0, 0);
        cap.delete();
        xfer_cnt = 0;
        done_cnt = 0;
        first_valid_cyc = -1;
        @(posedge clk); #1;
        full_screen = 1'b1;
        start       = 1'b1;
        chk_en      = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
        full_screen = 1'b0;
        for (int k = 0; k < 1000 && xfer_cnt < 50; k++) begin
            @(posedge clk); #1;
        end
        check("reached_beat_50", xfer_cnt, 50);
        #2;
        chk_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("arst_valid", int'(valid), 0);
        check("arst_busy",  int'(busy), 0);
        check("arst_done",  int'(done), 0);
        check("arst_x",     int'(out_x), 0);
        check("arst_y",     int'(out_y), 0);
        check("arst_addr",  int'(out_addr), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("no_done_after_reset", int'(done), 0);
            check("idle_after_reset", int'(busy), 0);
        end
        run_sweep(1'b1, 0, 0, 0, 0, -1, 0, -1);
        check("post_reset_count", cap.size(), 19200);
        if (cap.size() == 19200) check("post_reset_last", cap[19199].a, 19199);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
